// File: rtl/axi4lite_slave.sv
// AXI4-Lite slave with a 2^(ADDR_WIDTH-2) x 32-bit register file; independent write and read channels.
// Optional build macro AXIL_UNALIGNED_SLVERR_EN: unaligned writes are dropped and answered with SLVERR.
module axi4lite_slave #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int NUM_REGS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_ACK  = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_ACK  = 2'b01,
    R_DATA = 2'b10
  } r_state_t;

  w_state_t w_state_r, w_state_nxt_s;
  r_state_t r_state_r, r_state_nxt_s;

  logic                  awready_r;
  logic                  wready_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic                  arready_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  logic [ADDR_WIDTH-3:0] w_idx_s;
  logic [ADDR_WIDTH-3:0] r_idx_s;
  logic                  w_slverr_s;
  logic                  wr_en_s;
  logic                  unused_s;

  assign w_idx_s = s_axi_awaddr[ADDR_WIDTH-1:2];
  assign r_idx_s = s_axi_araddr[ADDR_WIDTH-1:2];

`ifdef AXIL_UNALIGNED_SLVERR_EN
  assign w_slverr_s = (s_axi_awaddr[1:0] != 2'b00);
`else
  assign w_slverr_s = 1'b0;
`endif

  // Low address bits are ignored by reads (and by writes in the default build).
  assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_en_s = (w_state_r == W_ACK) && !w_slverr_s;

  // Write channel next-state: accept only when address and data arrive together.
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid && !bvalid_r) begin
          w_state_nxt_s = W_ACK;
        end else begin
          w_state_nxt_s = W_IDLE;
        end
      end
      W_ACK: w_state_nxt_s = W_RESP;
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_nxt_s = W_IDLE;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write channel state and registered handshake/response outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      w_state_r <= w_state_nxt_s;
      awready_r <= (w_state_nxt_s == W_ACK);
      wready_r  <= (w_state_nxt_s == W_ACK);
      bvalid_r  <= (w_state_nxt_s == W_RESP);
      if (w_state_r == W_ACK) begin
        bresp_r <= w_slverr_s ? 2'b10 : 2'b00;
      end
    end
  end

  // Read channel next-state: one outstanding read, held until rready.
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (s_axi_arvalid && !rvalid_r) begin
          r_state_nxt_s = R_ACK;
        end else begin
          r_state_nxt_s = R_IDLE;
        end
      end
      R_ACK: r_state_nxt_s = R_DATA;
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_nxt_s = R_IDLE;
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Read channel state and registered outputs; rdata is captured before any same-edge write lands.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state_r <= r_state_nxt_s;
      arready_r <= (r_state_nxt_s == R_ACK);
      rvalid_r  <= (r_state_nxt_s == R_DATA);
      if (r_state_r == R_ACK) begin
        rdata_r <= regs_r[r_idx_s];
      end
    end
  end

  // Register file storage.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[w_idx_s] <= s_axi_wdata;
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_axi4lite_slave.sv
// Self-checking bench for axi4lite_slave: directed scenarios plus randomized concurrent traffic
// checked against an array model of the register file.
module tb_axi4lite_slave;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [16];

  axi4lite_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int addr);
    return (addr % 64) / 4;
  endfunction

  function automatic logic [1:0] exp_bresp(input int addr);
`ifdef AXIL_UNALIGNED_SLVERR_EN
    return (addr % 4 != 0) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic void model_write(input int addr, input logic [31:0] data);
    if (exp_bresp(addr) == 2'b00) model[idx_of(addr)] = data;
  endfunction

  task automatic start_write(input int addr, input logic [31:0] data);
    awaddr = AW'(addr);
    wdata = data;
    awvalid = 1'b1;
    wvalid = 1'b1;
  endtask

  task automatic start_read(input int addr);
    araddr = AW'(addr);
    arvalid = 1'b1;
  endtask

  // Waits for the write readies, lets the handshake edge pass, then drops the valids.
  task automatic wait_aw(output int lat);
    lat = 0;
    while (!awready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("aw_w_ready", {30'b0, awready, wready}, 32'd3);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    check_eq("aw_one_cycle", {30'b0, awready, wready}, 32'd0);
  endtask

  task automatic wait_ar(output int lat);
    lat = 0;
    while (!arready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ar_ready", {31'b0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("ar_one_cycle", {31'b0, arready}, 32'd0);
  endtask

  task automatic finish_b(input int delay, input logic [1:0] exp);
    check_eq("bvalid", {31'b0, bvalid}, 32'd1);
    check_eq("bresp", {30'b0, bresp}, {30'b0, exp});
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("bvalid_hold", {31'b0, bvalid}, 32'd1);
      check_eq("bresp_hold", {30'b0, bresp}, {30'b0, exp});
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("bvalid_clear", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic finish_r(input int delay, input logic [31:0] exp);
    check_eq("rvalid", {31'b0, rvalid}, 32'd1);
    check_eq("rdata", rdata, exp);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("rvalid_hold", {31'b0, rvalid}, 32'd1);
      check_eq("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_eq("rvalid_clear", {31'b0, rvalid}, 32'd0);
    check_eq("rdata_keep", rdata, exp);
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input int delay);
    int lat;
    start_write(addr, data);
    wait_aw(lat);
    check_eq("aw_latency", lat, 32'd1);
    finish_b(delay, exp_bresp(addr));
    model_write(addr, data);
  endtask

  task automatic do_read(input int addr, input int delay);
    int lat;
    start_read(addr);
    wait_ar(lat);
    check_eq("ar_latency", lat, 32'd1);
    finish_r(delay, model[idx_of(addr)]);
  endtask

  initial begin
    int lat;
    int lat2;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset held for two cycles with no valids or stale data visible.
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("reset_valids", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
      check_eq("reset_bresp_rdata", rdata | {30'b0, bresp}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 64; a += 4) do_read(a, 0);

    // Basic write/readback and untouched neighbour.
    do_write(8, 32'hDEADBEEF, 0);
    do_read(8, 0);
    check_eq("deadbeef_model", model[2], 32'hDEADBEEF);
    do_read(12, 0);

    // Address sweep, then 0x40 wraps onto register 0.
    for (int a = 0; a < 64; a += 4) do_write(a, 32'h1000_0000 + a, 0);
    for (int a = 0; a < 64; a += 4) do_read(a, 0);
    do_write(64, 32'hCAFE0040, 0);
    do_read(0, 0);

    // Backpressure on both channels.
    do_write(20, 32'h5555AAAA, 5);
    do_read(20, 5);

    // Second write presented during a stalled response must wait for bvalid to clear.
    start_write(24, 32'h24242424);
    wait_aw(lat);
    start_write(28, 32'h28282828);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("aw_blocked", {30'b0, awready, wready}, 32'd0);
      check_eq("bvalid_stall", {31'b0, bvalid}, 32'd1);
      check_eq("bresp_stall", {30'b0, bresp}, 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("bvalid_clear_b2b", {31'b0, bvalid}, 32'd0);
    model_write(24, 32'h24242424);
    wait_aw(lat2);
    check_eq("b2b_latency", lat2, 32'd1);
    finish_b(0, 2'b00);
    model_write(28, 32'h28282828);
    do_read(24, 0);
    do_read(28, 0);

    // Same-edge write and read of one register: read sees the old value.
    do_write(16, 32'h11111111, 0);
    start_write(16, 32'hA5A5A5A5);
    start_read(16);
    fork
      begin
        int l1;
        wait_aw(l1);
        finish_b(2, 2'b00);
      end
      begin
        int l2;
        wait_ar(l2);
        finish_r(1, 32'h11111111);
      end
    join
    model_write(16, 32'hA5A5A5A5);
    do_read(16, 0);

    // Unaligned write: SLVERR and no update only when the feature is built in.
    do_write(5, 32'h12345678, 0);
    do_read(4, 0);

    // Randomized concurrent traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int wa;
      int ra;
      int bd;
      int rd;
      logic [31:0] d;
      logic [31:0] pre;
      wa = int'($urandom_range(0, 63));
      ra = int'($urandom_range(0, 63));
      bd = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 3));
      d = $urandom;
      pre = model[idx_of(ra)];
      start_write(wa, d);
      start_read(ra);
      fork
        begin
          int l1;
          wait_aw(l1);
          finish_b(bd, exp_bresp(wa));
        end
        begin
          int l2;
          wait_ar(l2);
          finish_r(rd, pre);
        end
      join
      model_write(wa, d);
    end
    for (int a = 0; a < 64; a += 4) do_read(a, 0);

    // Reset while a write response is pending.
    start_write(36, 32'h77777777);
    wait_aw(lat);
    check_eq("bvalid_before_rst", {31'b0, bvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("bvalid_async_rst", {31'b0, bvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(negedge clk);
    for (int a = 0; a < 64; a += 4) do_read(a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
